// File: rtl/grad_weight_div.sv
// Gradient-pair to blend-weight converter: w_h = grad_v * 2^FRAC / (grad_h + grad_v)
// via a one-bit-per-cycle restoring divider, with w_v = 2^FRAC - w_h.
module grad_weight_div #(
    parameter int BITWIDTH = 16,
    parameter int FRAC     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITWIDTH-1:0] grad_h,
    input  logic [BITWIDTH-1:0] grad_v,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [FRAC:0]       w_h,
    output logic [FRAC:0]       w_v,
    output logic                flat,
    output logic                out_valid,
    input  logic                out_ready
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(FRAC + 1);
    localparam logic [FRAC:0]       ONE_W   = (FRAC + 1)'(1 << FRAC);
    localparam logic [BITWIDTH:0]   FLAT_SUM = (BITWIDTH + 1)'(2);
    localparam logic [BITWIDTH:0]   FLAT_NUM = (BITWIDTH + 1)'(1);
    localparam logic [CW-1:0]       CNT_INIT = CW'(FRAC);

    state_t              state;
    logic [BITWIDTH:0]   sum_r;
    logic [BITWIDTH:0]   rem_r;
    logic [FRAC:0]       q_r;
    logic [CW-1:0]       cnt_r;
    logic                flat_r;

    logic [BITWIDTH:0]   in_sum;
    logic                in_flat;
    logic [BITWIDTH:0]   div_sum;
    logic [BITWIDTH:0]   div_num;
    logic                q_top;
    logic [BITWIDTH:0]   rem_init;
    logic [BITWIDTH+1:0] rem2;
    logic [BITWIDTH+1:0] rem_sub;
    logic                rem_ge;

    // Sum is one bit wider than the gradients so 0xFFFF + 0xFFFF cannot wrap.
    assign in_sum   = {1'b0, grad_h} + {1'b0, grad_v};
    assign in_flat  = (in_sum == '0);
    assign div_sum  = in_flat ? FLAT_SUM : in_sum;
    assign div_num  = in_flat ? FLAT_NUM : {1'b0, grad_v};
    assign q_top    = (div_num >= div_sum);
    assign rem_init = q_top ? (div_num - div_sum) : div_num;

    // Remainder stays below sum, so the restored value always fits back in BITWIDTH+1 bits.
    assign rem2    = {rem_r, 1'b0};
    assign rem_ge  = (rem2 >= {1'b0, sum_r});
    assign rem_sub = rem2 - {1'b0, sum_r};

    assign in_ready = (state == IDLE);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum_r     <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            cnt_r     <= '0;
            flat_r    <= 1'b0;
            w_h       <= '0;
            w_v       <= '0;
            flat      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_r  <= div_sum;
                        rem_r  <= rem_init;
                        q_r    <= {q_top, {FRAC{1'b0}}};
                        cnt_r  <= CNT_INIT;
                        flat_r <= in_flat;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_r != '0) begin
                        q_r[cnt_r - 1'b1] <= rem_ge;
                        rem_r <= rem_ge ? rem_sub[BITWIDTH:0] : rem2[BITWIDTH:0];
                        cnt_r <= cnt_r - 1'b1;
                    end else begin
                        // All fraction bits resolved: publish the weights.
                        w_h       <= q_r;
                        w_v       <= ONE_W - q_r;
                        flat      <= flat_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
